// File: rtl/operand_stream_sequencer_pkg.sv
// Shared types and size helpers for the operand stream sequencer.
package operand_stream_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int DEF_LOG2_BYTES_IN  = 3;
  localparam int DEF_LOG2_BYTES_OUT = 2;
  localparam int DEF_WAIT_CYCLES    = 2;

  function automatic int bytes_of(input int log2_bytes);
    return 1 << log2_bytes;
  endfunction

endpackage

// File: rtl/operand_stream_sequencer.sv
// Converts a host valid/ready byte stream into datapath operand writes and
// streams the registered datapath result back out, one frame at a time.
module operand_stream_sequencer
  import operand_stream_sequencer_pkg::*;
#(
  parameter int LOG2_BYTES_IN  = DEF_LOG2_BYTES_IN,
  parameter int LOG2_BYTES_OUT = DEF_LOG2_BYTES_OUT,
  parameter int WAIT_CYCLES    = DEF_WAIT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [7:0]                dp_data_in,
  output logic [LOG2_BYTES_IN-1:0]  dp_sel_in,
  output logic                      dp_we,
  output logic [LOG2_BYTES_OUT-1:0] dp_sel_out,
  input  logic [7:0]                dp_result,
  output logic                      busy,
  output logic [7:0]                frame_count
);

  localparam int BYTES_IN  = bytes_of(LOG2_BYTES_IN);
  localparam int BYTES_OUT = bytes_of(LOG2_BYTES_OUT);
  localparam int WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [LOG2_BYTES_IN-1:0]  IN_LAST   = LOG2_BYTES_IN'(BYTES_IN - 1);
  localparam logic [LOG2_BYTES_OUT-1:0] OUT_LAST  = LOG2_BYTES_OUT'(BYTES_OUT - 1);
  localparam logic [WAIT_W-1:0]         WAIT_INIT = WAIT_W'(WAIT_CYCLES - 1);

  state_t                      state_r, state_s;
  logic [LOG2_BYTES_IN-1:0]    in_cnt_r, in_cnt_s;
  logic [LOG2_BYTES_OUT-1:0]   out_cnt_r, out_cnt_s;
  logic [WAIT_W-1:0]           wait_cnt_r, wait_cnt_s;
  logic [7:0]                  frame_count_r, frame_count_s;
  logic                        in_ready_s, out_valid_s, dp_we_s, busy_s;

  // Output decode and next-state/counter logic; flush overrides all sequencing.
  always_comb begin
    state_s       = state_r;
    in_cnt_s      = in_cnt_r;
    out_cnt_s     = out_cnt_r;
    wait_cnt_s    = wait_cnt_r;
    frame_count_s = frame_count_r;
    in_ready_s    = 1'b0;
    out_valid_s   = 1'b0;
    dp_we_s       = 1'b0;
    busy_s        = 1'b0;

    case (state_r)
      ST_LOAD: begin
        in_ready_s = 1'b1;
        dp_we_s    = in_valid & ~flush;
      end
      ST_WAIT: begin
        busy_s = 1'b1;
      end
      ST_SEND: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase

    if (flush) begin
      state_s    = ST_LOAD;
      in_cnt_s   = {LOG2_BYTES_IN{1'b0}};
      out_cnt_s  = {LOG2_BYTES_OUT{1'b0}};
      wait_cnt_s = {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (in_valid) begin
            if (in_cnt_r == IN_LAST) begin
              in_cnt_s   = {LOG2_BYTES_IN{1'b0}};
              wait_cnt_s = WAIT_INIT;
              state_s    = ST_WAIT;
            end else begin
              in_cnt_s = in_cnt_r + LOG2_BYTES_IN'(1);
            end
          end else begin
            in_cnt_s = in_cnt_r;
          end
        end
        // Terminal count of zero means the result register is already valid.
        ST_WAIT: begin
          if (wait_cnt_r == {WAIT_W{1'b0}}) begin
            state_s = ST_SEND;
          end else begin
            wait_cnt_s = wait_cnt_r - WAIT_W'(1);
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (out_cnt_r == OUT_LAST) begin
              out_cnt_s     = {LOG2_BYTES_OUT{1'b0}};
              frame_count_s = frame_count_r + 8'd1;
              state_s       = ST_LOAD;
            end else begin
              out_cnt_s = out_cnt_r + LOG2_BYTES_OUT'(1);
            end
          end else begin
            out_cnt_s = out_cnt_r;
          end
        end
        default: begin
          state_s    = ST_LOAD;
          in_cnt_s   = {LOG2_BYTES_IN{1'b0}};
          out_cnt_s  = {LOG2_BYTES_OUT{1'b0}};
          wait_cnt_s = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_LOAD;
      in_cnt_r      <= {LOG2_BYTES_IN{1'b0}};
      out_cnt_r     <= {LOG2_BYTES_OUT{1'b0}};
      wait_cnt_r    <= {WAIT_W{1'b0}};
      frame_count_r <= 8'd0;
    end else begin
      state_r       <= state_s;
      in_cnt_r      <= in_cnt_s;
      out_cnt_r     <= out_cnt_s;
      wait_cnt_r    <= wait_cnt_s;
      frame_count_r <= frame_count_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign dp_we       = dp_we_s;
  assign busy        = busy_s;
  assign frame_count = frame_count_r;
  assign dp_data_in  = in_data;
  assign dp_sel_in   = in_cnt_r;
  assign dp_sel_out  = out_cnt_r;
  assign out_data    = dp_result;

endmodule

// File: tb/tb_operand_stream_sequencer.sv
// Directed scoreboard bench: two sequencers (WAIT_CYCLES 2 and 1), each wired
// to a behavioural add datapath with a registered 32-bit result.
module tb_operand_stream_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data     [2];
  logic       in_valid    [2];
  logic       in_ready    [2];
  logic [7:0] out_data    [2];
  logic       out_valid   [2];
  logic       out_ready   [2];
  logic       flush       [2];
  logic [7:0] dp_data_in  [2];
  logic [2:0] dp_sel_in   [2];
  logic       dp_we       [2];
  logic [1:0] dp_sel_out  [2];
  logic [7:0] dp_result   [2];
  logic       busy        [2];
  logic [7:0] frame_count [2];

  int         checks;
  int         fails;
  int         fc_exp [2];
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  operand_stream_sequencer #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .flush(flush[0]),
    .dp_data_in(dp_data_in[0]), .dp_sel_in(dp_sel_in[0]), .dp_we(dp_we[0]),
    .dp_sel_out(dp_sel_out[0]), .dp_result(dp_result[0]),
    .busy(busy[0]), .frame_count(frame_count[0])
  );

  operand_stream_sequencer #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .flush(flush[1]),
    .dp_data_in(dp_data_in[1]), .dp_sel_in(dp_sel_in[1]), .dp_we(dp_we[1]),
    .dp_sel_out(dp_sel_out[1]), .dp_result(dp_result[1]),
    .busy(busy[1]), .frame_count(frame_count[1])
  );

  // Behavioural datapath: byte-written operand register, registered x + y.
  for (genvar g = 0; g < 2; g++) begin : g_dp
    logic [7:0]  op_r [8];
    logic [31:0] sum_r;
    always @(posedge clk) begin
      if (dp_we[g]) op_r[dp_sel_in[g]] <= dp_data_in[g];
      sum_r <= {op_r[3], op_r[2], op_r[1], op_r[0]} + {op_r[7], op_r[6], op_r[5], op_r[4]};
    end
    assign dp_result[g] = sum_r[{dp_sel_out[g], 3'b000} +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives n operand bytes of frame f (byte 0 in f[7:0]); a full frame queues its sum.
  task automatic load_frame(input int d, input logic [63:0] f, input int n, input bit gaps);
    logic [31:0] s;
    s = f[31:0] + f[63:32];
    if (n == 8) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(s[8*k +: 8]);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        @(negedge clk); in_valid[d] = 1'b0; in_data[d] = 8'hA5; #1;
        chk("gap_no_we", 32'(dp_we[d]), 32'd0);
      end
      @(negedge clk); in_valid[d] = 1'b1; in_data[d] = f[8*i +: 8]; #1;
      chk("load_ready", 32'(in_ready[d]), 32'd1);
      chk("load_we", 32'(dp_we[d]), 32'd1);
      chk("load_sel", 32'(dp_sel_in[d]), 32'(i));
      chk("load_data", 32'(dp_data_in[d]), 32'(f[8*i +: 8]));
    end
  endtask

  // Waits for the result, then drains stop_after bytes against the scoreboard.
  task automatic receive(input int d, input int wait_exp, input int stall_byte, input int stop_after);
    int lat;
    logic [7:0] held_data;
    logic [1:0] held_sel;
    logic [7:0] exp_b;
    lat = 0;
    @(negedge clk); in_valid[d] = 1'b1; in_data[d] = 8'hEE; out_ready[d] = 1'b0; #1;
    while (!out_valid[d] && lat < 20) begin
      chk("wait_busy", 32'(busy[d]), 32'd1);
      chk("wait_no_we", 32'(dp_we[d]), 32'd0);
      chk("wait_not_ready", 32'(in_ready[d]), 32'd0);
      lat++;
      @(negedge clk); #1;
    end
    chk("first_valid_latency", 32'(lat), 32'(wait_exp));
    for (int b = 0; b < stop_after; b++) begin
      if (b > 0) begin @(negedge clk); #1; end
      if (b == stall_byte) begin
        out_ready[d] = 1'b0; #1;
        held_data = out_data[d];
        held_sel  = dp_sel_out[d];
        for (int s = 0; s < 3; s++) begin
          @(negedge clk); #1;
          chk("stall_valid", 32'(out_valid[d]), 32'd1);
          chk("stall_data", 32'(out_data[d]), 32'(held_data));
          chk("stall_sel", 32'(dp_sel_out[d]), 32'(held_sel));
          chk("stall_no_we", 32'(dp_we[d]), 32'd0);
        end
      end
      out_ready[d] = 1'b1; #1;
      chk("send_valid", 32'(out_valid[d]), 32'd1);
      chk("send_sel", 32'(dp_sel_out[d]), 32'(b));
      chk("send_no_we", 32'(dp_we[d]), 32'd0);
      chk("send_not_ready", 32'(in_ready[d]), 32'd0);
      chk("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk("send_data", 32'(out_data[d]), 32'(exp_b));
    end
    if (stop_after == 4) begin
      @(negedge clk); in_valid[d] = 1'b0; out_ready[d] = 1'b0; #1;
      fc_exp[d] = (fc_exp[d] + 1) % 256;
      chk("b2b_in_ready", 32'(in_ready[d]), 32'd1);
      chk("idle_out_valid", 32'(out_valid[d]), 32'd0);
      chk("idle_busy", 32'(busy[d]), 32'd0);
      chk("frame_count", 32'(frame_count[d]), 32'(fc_exp[d]));
    end
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
    chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_dp_we", 32'(dp_we[d]), 32'd0);
    chk("rst_frame_count", 32'(frame_count[d]), 32'd0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_data[d] = 8'h00; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      flush[d] = 1'b0; fc_exp[d] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(negedge clk); rst_n = 1'b1; #1;
    chk_reset_outputs(0);

    // Basic frame, carry drop, mixed operands.
    load_frame(0, 64'h00000002_00000001, 8, 1'b0);
    receive(0, 2, -1, 4);
    load_frame(0, 64'h00000001_FFFFFFFF, 8, 1'b0);
    receive(0, 2, -1, 4);
    load_frame(0, 64'h11111111_12345678, 8, 1'b0);
    receive(0, 2, -1, 4);

    // Gapped input and a 3-cycle output stall on byte 2.
    load_frame(0, 64'h0BADF00D_12345678, 8, 1'b1);
    receive(0, 2, 2, 4);

    // Flush after 5 bytes with a byte presented in the flush cycle.
    load_frame(0, 64'hDEADBEEF_CAFEF00D, 5, 1'b0);
    @(negedge clk); flush[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'h5A; #1;
    chk("flush_no_we", 32'(dp_we[0]), 32'd0);
    @(negedge clk); flush[0] = 1'b0; in_valid[0] = 1'b0; #1;
    chk("flush_frame_count", 32'(frame_count[0]), 32'(fc_exp[0]));
    chk("flush_in_ready", 32'(in_ready[0]), 32'd1);
    chk("flush_sel_cleared", 32'(dp_sel_in[0]), 32'd0);
    load_frame(0, 64'h80706050_F0E0D0C0, 8, 1'b0);
    receive(0, 2, -1, 4);

    // Reset pulse during SEND after byte 1.
    load_frame(0, 64'h00000100_000000FF, 8, 1'b0);
    receive(0, 2, -1, 2);
    @(negedge clk); rst_n = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b0; #1;
    chk_reset_outputs(0);
    exp_q.delete();
    fc_exp[0] = 0;
    fc_exp[1] = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk_reset_outputs(0);
    load_frame(0, 64'h00000005_00000007, 8, 1'b0);
    receive(0, 2, -1, 4);

    // WAIT_CYCLES = 1 instance, back-to-back frames.
    load_frame(1, 64'h01020304_A0B0C0D0, 8, 1'b0);
    receive(1, 1, -1, 4);
    load_frame(1, 64'hFFFFFFFF_00000002, 8, 1'b0);
    receive(1, 1, -1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
